// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory / MMIO responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] OFF_DUTY = 4'h0;
  localparam logic [3:0] OFF_US   = 4'h4;
  localparam logic [3:0] OFF_MS   = 4'h8;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_MMIO,
    RGN_NONE
  } region_e;

  typedef struct packed {
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: registered compare of the shared 8-bit counter against a duty byte.
module pwm_channel (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] duty_i,
  input  logic [7:0] cnt_i,
  output logic       pwm_o
);

  logic pwm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_q <= 1'b0;
    else       pwm_q <= (cnt_i < duty_i);
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Memory-side responder for the data bus: word RAM, PWM duty register and us/ms timers.
// Build option MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of aligning them.
module dmem_mmio_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 2048,
  parameter int unsigned CLK_HZ     = 12000000,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        dmem_wren,
  input  logic [2:0]  funct3,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic        rsp_valid,
  output logic [31:0] dmem_data_out,
  output logic        fault,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned AW        = $clog2(DMEM_WORDS);
  localparam int unsigned PRE_MAX   = CLK_HZ / 1000000;
  localparam logic [31:0] RAM_BYTES = 32'(DMEM_WORDS * 4);
  localparam logic [31:0] PRE_LAST  = 32'(PRE_MAX - 1);

  dmem_req_t   req;
  region_e     rgn;
  logic        is_half, is_word, f3_ok, bad, tick;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [3:0]  off;
  logic [AW-1:0] widx;
  logic [31:0] wlanes, rd_word, shifted, ld_data;

  logic [31:0] mem_q [DMEM_WORDS];
  logic [31:0] duty_q, duty_d, pre_q, pre_d, us_q, us_d, ms_q, ms_d;
  logic [9:0]  sub_q, sub_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d, fault_q, fault_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  pwm;

  assign req  = '{wren: dmem_wren, f3: funct3, addr: dmem_address, wdata: dmem_data_in};
  assign widx = req.addr[AW+1:2];
  assign off  = {req.addr[3:2], 2'b00};

  // Decode region, legality, lanes and load data for the request in flight.
  always_comb begin
    rgn     = RGN_NONE;
    be      = 4'b0000;
    wlanes  = req.wdata;
    rd_word = 32'd0;
    ld_data = 32'd0;
    duty_d  = duty_q;

    if (req.addr < RAM_BYTES)                    rgn = RGN_RAM;
    else if (req.addr[31:4] == MMIO_BASE[31:4])  rgn = RGN_MMIO;

    is_half = (req.f3[1:0] == 2'b01);
    is_word = (req.f3[1:0] == 2'b10);
    f3_ok   = req.wren ? (req.f3 inside {F3_B, F3_H, F3_W})
                       : (req.f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef MISALIGN_TRAP_EN
    lane = req.addr[1:0];
    bad  = !f3_ok || (is_half && req.addr[0]) || (is_word && (req.addr[1:0] != 2'b00));
`else
    lane = is_word ? 2'b00 : (is_half ? {req.addr[1], 1'b0} : req.addr[1:0]);
    bad  = !f3_ok;
`endif

    if (req_valid && req.wren && !bad && !reset) begin
      case (req.f3)
        F3_B:    be = 4'(4'b0001 << lane);
        F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
        F3_W:    be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
    case (req.f3)
      F3_B:    wlanes = {4{req.wdata[7:0]}};
      F3_H:    wlanes = {2{req.wdata[15:0]}};
      default: wlanes = req.wdata;
    endcase

    case (rgn)
      RGN_RAM:  rd_word = mem_q[widx];
      RGN_MMIO: begin
        case (off)
          OFF_DUTY: rd_word = duty_q;
          OFF_US:   rd_word = us_q;
          OFF_MS:   rd_word = ms_q;
          default:  rd_word = 32'd0;
        endcase
      end
      default:  rd_word = 32'd0;
    endcase

    shifted = rd_word >> {lane, 3'b000};
    if (!req.wren && !bad) begin
      case (req.f3)
        F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
        F3_BU:   ld_data = {24'd0, shifted[7:0]};
        F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
        F3_HU:   ld_data = {16'd0, shifted[15:0]};
        F3_W:    ld_data = rd_word;
        default: ld_data = 32'd0;
      endcase
    end

    // Duty is the only writable MMIO register; timer offsets ignore stores.
    if (rgn == RGN_MMIO && off == OFF_DUTY) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) duty_d[8*i +: 8] = wlanes[8*i +: 8];
    end
  end

  // Response, PWM counter and timer next-state.
  always_comb begin
    rsp_valid_d = req_valid;
    data_d      = req_valid ? ld_data : 32'd0;
    fault_d     = req_valid && bad;
    cnt_d       = cnt_q + 8'd1;
    tick        = (pre_q == PRE_LAST);
    pre_d       = tick ? 32'd0 : pre_q + 32'd1;
    us_d        = us_q + 32'(tick);
    sub_d       = sub_q;
    ms_d        = ms_q;
    if (tick) begin
      if (sub_q == 10'd999) begin
        sub_d = 10'd0;
        ms_d  = ms_q + 32'd1;
      end else begin
        sub_d = sub_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      data_q      <= 32'd0;
      fault_q     <= 1'b0;
      duty_q      <= 32'd0;
      cnt_q       <= 8'd0;
      pre_q       <= 32'd0;
      us_q        <= 32'd0;
      sub_q       <= 10'd0;
      ms_q        <= 32'd0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      data_q      <= data_d;
      fault_q     <= fault_d;
      duty_q      <= duty_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      us_q        <= us_d;
      sub_q       <= sub_d;
      ms_q        <= ms_d;
    end
  end

  // RAM is not reset; be is already gated off while reset is high.
  always_ff @(posedge clk) begin
    if (rgn == RGN_RAM) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[widx][8*i +: 8] <= wlanes[8*i +: 8];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pwm
    pwm_channel u_pwm (
      .clk    (clk),
      .reset  (reset),
      .duty_i (duty_q[8*g +: 8]),
      .cnt_i  (cnt_q),
      .pwm_o  (pwm[g])
    );
  end

  assign rsp_valid     = rsp_valid_q;
  assign dmem_data_out = data_q;
  assign fault         = fault_q;
  assign led           = pwm[0];
  assign red           = pwm[1];
  assign green         = pwm[2];
  assign blue          = pwm[3];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder, built with CLK_HZ = 4 MHz (4 cycles per us).
module tb_dmem_mmio_responder;

  localparam logic [31:0] MB = 32'hFFFF_FFF0;

  logic        clk, reset, req_valid, dmem_wren;
  logic [2:0]  funct3;
  logic [31:0] dmem_address, dmem_data_in, dmem_data_out;
  logic        rsp_valid, fault, led, red, green, blue;

  logic        r_valid, r_fault;
  logic [31:0] r_data;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          c_led, c_red, c_green, c_blue;

  dmem_mmio_responder #(.DMEM_WORDS(2048), .CLK_HZ(4000000), .MMIO_BASE(MB)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .dmem_wren     (dmem_wren),
    .funct3        (funct3),
    .dmem_address  (dmem_address),
    .dmem_data_in  (dmem_data_in),
    .rsp_valid     (rsp_valid),
    .dmem_data_out (dmem_data_out),
    .fault         (fault),
    .led           (led),
    .red           (red),
    .green         (green),
    .blue          (blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request, driven at a negedge; the response is sampled at the next negedge.
  task automatic xfer(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; dmem_wren = wr; funct3 = f3; dmem_address = a; dmem_data_in = d;
    @(negedge clk);
    r_valid = rsp_valid; r_data = dmem_data_out; r_fault = fault;
    req_valid = 1'b0; dmem_wren = 1'b0;
  endtask

  task automatic acc(input string tag, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_data, input logic exp_fault);
    xfer(wr, f3, a, d);
    chk({tag, "_valid"}, 32'(r_valid), 32'd1);
    chk({tag, "_data"}, r_data, exp_data);
    chk({tag, "_fault"}, 32'(r_fault), 32'(exp_fault));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; dmem_wren = 1'b0; funct3 = 3'b000;
    dmem_address = 32'd0; dmem_data_in = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", dmem_data_out, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_pwm", 32'({led, red, green, blue}), 32'd0);
    reset = 1'b0;

    // RAM byte/half/word access and read-after-write.
    acc("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'd0, 1'b0);
    acc("lb103", 1'b0, 3'b000, 32'h103, 32'd0, 32'hFFFFFFDE, 1'b0);
    acc("lbu100", 1'b0, 3'b100, 32'h100, 32'd0, 32'h000000EF, 1'b0);
    acc("lh102", 1'b0, 3'b001, 32'h102, 32'd0, 32'hFFFFDEAD, 1'b0);
    @(negedge clk);
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    acc("sb101", 1'b1, 3'b000, 32'h101, 32'h00000055, 32'd0, 1'b0);
    acc("lw100", 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD55EF, 1'b0);
    acc("lhu100", 1'b0, 3'b101, 32'h100, 32'd0, 32'h000055EF, 1'b0);
    acc("sw104", 1'b1, 3'b010, 32'h104, 32'h12345678, 32'd0, 1'b0);
    acc("st011", 1'b1, 3'b011, 32'h104, 32'h00000000, 32'd0, 1'b1);
    acc("lw104", 1'b0, 3'b010, 32'h104, 32'd0, 32'h12345678, 1'b0);
    acc("ld011", 1'b0, 3'b011, 32'h104, 32'd0, 32'd0, 1'b1);
    acc("sw1ffc", 1'b1, 3'b010, 32'h1FFC, 32'hCAFEF00D, 32'd0, 1'b0);
    acc("lw1ffc", 1'b0, 3'b010, 32'h1FFC, 32'd0, 32'hCAFEF00D, 1'b0);
    acc("sw2000", 1'b1, 3'b010, 32'h2000, 32'hFFFFFFFF, 32'd0, 1'b0);
    acc("lw2000", 1'b0, 3'b010, 32'h2000, 32'd0, 32'd0, 1'b0);

    // Duty register byte lanes and the reserved offset.
    acc("swduty", 1'b1, 3'b010, MB, 32'h11223344, 32'd0, 1'b0);
    acc("sbduty", 1'b1, 3'b000, MB + 32'd1, 32'h000000AA, 32'd0, 1'b0);
    acc("lwduty", 1'b0, 3'b010, MB, 32'd0, 32'h1122AA44, 1'b0);
    acc("lwoffc", 1'b0, 3'b010, MB + 32'hC, 32'd0, 32'd0, 1'b0);

    // Timers from a fresh reset: 4000 cycles at 4 cycles/us.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4000) @(negedge clk);
    acc("us1000", 1'b0, 3'b010, MB + 32'h4, 32'd0, 32'd1000, 1'b0);
    acc("ms1", 1'b0, 3'b010, MB + 32'h8, 32'd0, 32'd1, 1'b0);
    acc("swus", 1'b1, 3'b010, MB + 32'h4, 32'h12345678, 32'd0, 1'b0);
    acc("us_ro", 1'b0, 3'b010, MB + 32'h4, 32'd0, 32'd1000, 1'b0);

    // PWM duty over one full counter period.
    acc("swpwm", 1'b1, 3'b010, MB, 32'h408000FF, 32'd0, 1'b0);
    acc("lbu_blue", 1'b0, 3'b100, MB + 32'd3, 32'd0, 32'h00000040, 1'b0);
    repeat (2) @(negedge clk);
    c_led = 0; c_red = 0; c_green = 0; c_blue = 0;
    repeat (256) begin
      @(negedge clk);
      c_led += int'(led); c_red += int'(red); c_green += int'(green); c_blue += int'(blue);
    end
    chk("pwm_led", 32'(c_led), 32'd255);
    chk("pwm_red", 32'(c_red), 32'd0);
    chk("pwm_green", 32'(c_green), 32'd128);
    chk("pwm_blue", 32'(c_blue), 32'd64);

    // Misaligned accesses; 0x100 holds DEAD55EF, 0x104 holds 12345678.
`ifdef MISALIGN_TRAP_EN
    acc("lw102", 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 1'b1);
    acc("lh101", 1'b0, 3'b001, 32'h101, 32'd0, 32'd0, 1'b1);
    acc("sh105", 1'b1, 3'b001, 32'h105, 32'h0000AAAA, 32'd0, 1'b1);
    acc("lw104m", 1'b0, 3'b010, 32'h104, 32'd0, 32'h12345678, 1'b0);
`else
    acc("lw102", 1'b0, 3'b010, 32'h102, 32'd0, 32'hDEAD55EF, 1'b0);
    acc("lh101", 1'b0, 3'b001, 32'h101, 32'd0, 32'h000055EF, 1'b0);
    acc("sh105", 1'b1, 3'b001, 32'h105, 32'h0000AAAA, 32'd0, 1'b0);
    acc("lw104m", 1'b0, 3'b010, 32'h104, 32'd0, 32'h1234AAAA, 1'b0);
`endif

    // Reset with a response in flight and a store presented during reset.
    acc("swfull", 1'b1, 3'b010, MB, 32'hFFFFFFFF, 32'd0, 1'b0);
    req_valid = 1'b1; dmem_wren = 1'b0; funct3 = 3'b010; dmem_address = 32'h100;
    @(posedge clk);
    #1;
    chk("pend_valid", 32'(rsp_valid), 32'd1);
    reset = 1'b1; dmem_wren = 1'b1; dmem_data_in = 32'h11111111;
    #1;
    chk("rstmid_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_pwm", 32'({led, red, green, blue}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; dmem_wren = 1'b0;
    acc("post_duty", 1'b0, 3'b010, MB, 32'd0, 32'd0, 1'b0);
    acc("post_us", 1'b0, 3'b010, MB + 32'h4, 32'd0, 32'd0, 1'b0);
    acc("post_ms", 1'b0, 3'b010, MB + 32'h8, 32'd0, 32'd0, 1'b0);
    acc("post_ram", 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD55EF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Responder (memory side) of the processor's data-memory interface. Accepts load/store requests carrying funct3, write enable, address and write data, and returns load data one cycle later. Decodes the address into word RAM or memory-mapped I/O (LED/RGB PWM duty register, microsecond and millisecond timers). Drives the LED/RGB outputs that the top level inverts onto the pins.

Parameters:
DMEM_WORDS, 2048, RAM depth in 32-bit words; RAM occupies 0x0000_0000 to DMEM_WORDS*4-1
CLK_HZ, 12000000, clk frequency; sets the microsecond prescaler (CLK_HZ/1_000_000 cycles per us)
MMIO_BASE, 32'hFFFF_FFF0, base of the 16-byte MMIO window

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present this cycle
dmem_wren  in  1  1 = store, 0 = load
funct3  in  3  RV32I width/sign code
dmem_address  in  32  byte address
dmem_data_in  in  32  store data, right-justified
rsp_valid  out  1  response valid; registered
dmem_data_out  out  32  load result; sign/zero-extended; registered
fault  out  1  misaligned or illegal funct3; qualifies rsp_valid
led  out  1  PWM output, active-high
red  out  1  PWM output, active-high
green  out  1  PWM output, active-high
blue  out  1  PWM output, active-high

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- Reset values:
  - rsp_valid=0, dmem_data_out=0, fault=0.
  - Duty register=0, so led/red/green/blue=0.
  - PWM counter=0, prescaler=0, us=0, ms=0, sub-ms count=0.
  - RAM contents are not reset.
- Handshake:
  - A request is accepted in every cycle that req_valid=1; there is no stall.
  - The response appears exactly 1 cycle later: rsp_valid=1 for one cycle, with dmem_data_out and fault.
  - Back-to-back requests produce back-to-back responses.
  - rsp_valid=1 also on stores; dmem_data_out=0 for stores.
- Address decode:
  - RAM: address < DMEM_WORDS*4.
  - MMIO: address within MMIO_BASE..MMIO_BASE+15.
  - Anything else is unmapped: loads return 0, stores are dropped, fault=0.
- Loads, funct3:
  - 000 lb: sign-extend selected byte.
  - 001 lh: sign-extend selected half.
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - Other codes: fault=1, data 0.
- Stores, funct3:
  - 000 sb: write byte lane addr[1:0] only.
  - 001 sh: write half lane addr[1].
  - 010 sw: write all four lanes.
  - Other codes: fault=1, no write.
- Read-after-write: a load in cycle N+1 to the address stored in cycle N returns the new data.
- MMIO map, offset from MMIO_BASE:
  - +0 duty: R/W, byte-lane writable. [7:0]=led, [15:8]=red, [23:16]=green, [31:24]=blue.
  - +4 us counter: RO, writes ignored.
  - +8 ms counter: RO, writes ignored.
  - +C: reads 0.
- PWM:
  - Free-running 8-bit counter, wraps 255 to 0.
  - Each output is registered and equals (counter < duty). Duty 0 gives constant 0; duty 255 gives high 255/256 of the period.
  - A duty write takes effect on the cycle after the write.
- Timers:
  - Prescaler counts 0..CLK_HZ/1_000_000-1; us increments on the terminal count.
  - A sub-ms counter 0..999 advances on each us tick; ms increments when it wraps.
  - us and ms wrap modulo 2^32.
- Reset mid-operation: an in-flight response is dropped (rsp_valid=0 next cycle). A store in the reset cycle has no effect.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Misaligned access sets fault=1, suppresses the write, and returns data 0.
  - Misaligned means: half access with addr[0]=1, or word access with addr[1:0]!=0.
- Undefined:
  - Low address bits are forced aligned (half: addr[0]=0; word: addr[1:0]=0); the access proceeds normally.
  - fault is asserted only for illegal funct3.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - MMIO offset constants OFF_DUTY, OFF_US, OFF_MS.
  - Region enum RGN_RAM, RGN_MMIO, RGN_NONE.
- Sub-module pwm_channel: 8-bit duty in, shared counter in, registered out; instantiated 4 times.

Test Plan:
- sw 0xDEADBEEF @0x100, then lb @0x103 -> 0xFFFFFFDE; lbu @0x100 -> 0x000000EF; lh @0x102 -> 0xFFFFDEAD; rsp_valid 1 cycle after each request.
- sb 0x55 @0x101 over 0xDEADBEEF, then lw @0x100 -> 0xDEAD55EF; other lanes untouched.
- sw 0x40_80_00_FF @MMIO_BASE -> over 256 cycles: led high 255, red 0, green 128, blue 64 cycles.
- CLK_HZ=4_000_000, run 4000 cycles, lw @MMIO_BASE+4 -> 1000; lw @MMIO_BASE+8 -> 1; sw to +4 leaves the value unchanged.
- lw @0x102: with MISALIGN_TRAP_EN -> fault=1, data 0; without -> data from 0x100, fault=0. funct3=011 -> fault=1 in both builds.
- Assert reset during a pending load -> rsp_valid=0, duty=0, timers=0 immediately.
